// File: rtl/trace_exec_pkg.sv
// Trace word layout shared by the packer, its FIFO and the trace stream interface.
package trace_exec_pkg;

  localparam int TRACE_EXEC_WIDTH = 103;

  localparam int ENABLE_LSB = 0;
  localparam int ENABLE_MSB = 0;
  localparam int INSN_LSB   = 1;
  localparam int INSN_MSB   = 32;
  localparam int PC_LSB     = 33;
  localparam int PC_MSB     = 64;
  localparam int WBEN_LSB   = 65;
  localparam int WBEN_MSB   = 65;
  localparam int WBREG_LSB  = 66;
  localparam int WBREG_MSB  = 70;
  localparam int WBDATA_LSB = 71;
  localparam int WBDATA_MSB = 102;

  // Declared MSB first so the packed bit positions match the layout above.
  typedef struct packed {
    logic [31:0] wbdata;
    logic [4:0]  wbreg;
    logic        wben;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        enable;
  } trace_exec_t;

endpackage

// File: rtl/trace_exec_packer_if.sv
// Valid/ready stream carrying packed trace words from the packer to the consumer.
interface trace_exec_packer_if;
  import trace_exec_pkg::*;

  logic                        trace_valid;
  logic                        trace_ready;
  logic [TRACE_EXEC_WIDTH-1:0] trace_word;

  modport master (output trace_valid, output trace_word, input trace_ready);
  modport slave  (input trace_valid, input trace_word, output trace_ready);

endinterface

// File: rtl/trace_exec_fifo.sv
// Synchronous FIFO with registered storage; written data is visible on o_rdata
// the cycle after the push. Pointers carry an extra MSB to tell full from empty.
module trace_exec_fifo #(
  parameter int WIDTH = 103,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; a reset simply empties the FIFO, storage keeps stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write at the current write slot.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/trace_exec_packer.sv
// Execution-trace packer: packs retired-instruction events into trace words,
// buffers them and streams them out, counting events lost to overflow.
// Optional feature macro: TRACE_EXEC_R3_SHADOW_EN adds the r3_shadow output.
module trace_exec_packer
  import trace_exec_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_sys,
  input  logic                      retire_valid,
  input  logic [31:0]               retire_pc,
  input  logic [31:0]               retire_insn,
  input  logic                      retire_wben,
  input  logic [4:0]                retire_wbreg,
  input  logic [31:0]               retire_wbdata,
  trace_exec_packer_if.master       trace_if,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
  input  logic                      drop_clr,
  output logic                      overflow
`ifdef TRACE_EXEC_R3_SHADOW_EN
  ,
  output logic [31:0]               r3_shadow
`endif
);

  trace_exec_t                 w_pkt;
  logic [TRACE_EXEC_WIDTH-1:0] w_rdata;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_pop;
  logic                        w_push;
  logic                        w_drop;
  logic                        w_sat;

  logic [DROP_CNT_WIDTH-1:0]   r_drop_cnt;
  logic                        r_overflow;

  // Pack the retire event; r0 is hardwired so a write to it is not a writeback.
  always_comb begin
    w_pkt        = '0;
    w_pkt.enable = 1'b1;
    w_pkt.insn   = retire_insn;
    w_pkt.pc     = retire_pc;
    w_pkt.wben   = retire_wben && (retire_wbreg != 5'd0);
    w_pkt.wbreg  = retire_wbreg;
    w_pkt.wbdata = retire_wbdata;
  end

  assign w_pop  = trace_if.trace_valid && trace_if.trace_ready;
  assign w_push = retire_valid && (!w_full || w_pop);
  assign w_drop = retire_valid && w_full && !w_pop;
  assign w_sat  = (r_drop_cnt == {DROP_CNT_WIDTH{1'b1}});

  trace_exec_fifo #(
    .WIDTH (TRACE_EXEC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst_sys),
    .i_push  (w_push),
    .i_wdata (w_pkt),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign trace_if.trace_valid = !w_empty;
  assign trace_if.trace_word  = w_rdata;

  // Saturating drop counter and sticky overflow; a drop in the clear cycle wins.
  always_ff @(posedge clk) begin
    if (rst_sys) begin
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (drop_clr)    r_drop_cnt <= DROP_CNT_WIDTH'(1);
      else if (!w_sat) r_drop_cnt <= r_drop_cnt + DROP_CNT_WIDTH'(1);
    end else if (drop_clr) begin
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end
  end

  assign drop_cnt = r_drop_cnt;
  assign overflow = r_overflow;

`ifdef TRACE_EXEC_R3_SHADOW_EN
  logic [31:0] r_r3_shadow;

  // Track the last r3 writeback at push time, regardless of how far the drain lags.
  always_ff @(posedge clk) begin
    if (rst_sys) begin
      r_r3_shadow <= '0;
    end else if (w_push && w_pkt.wben && (retire_wbreg == 5'd3)) begin
      r_r3_shadow <= retire_wbdata;
    end
  end

  assign r3_shadow = r_r3_shadow;
`endif

endmodule

// File: tb/tb_trace_exec_packer.sv
// Directed self-checking bench for trace_exec_packer (FIFO_DEPTH=4, 16-bit drop counter).
module tb_trace_exec_packer;

  logic        clk = 1'b0;
  logic        rst_sys;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic [31:0] retire_insn;
  logic        retire_wben;
  logic [4:0]  retire_wbreg;
  logic [31:0] retire_wbdata;
  logic [15:0] drop_cnt;
  logic        drop_clr;
  logic        overflow;
`ifdef TRACE_EXEC_R3_SHADOW_EN
  logic [31:0] r3_shadow;
`endif

  int checks = 0;
  int errors = 0;

  trace_exec_packer_if tif ();

  trace_exec_packer #(
    .FIFO_DEPTH     (4),
    .DROP_CNT_WIDTH (16)
  ) dut (
    .clk           (clk),
    .rst_sys       (rst_sys),
    .retire_valid  (retire_valid),
    .retire_pc     (retire_pc),
    .retire_insn   (retire_insn),
    .retire_wben   (retire_wben),
    .retire_wbreg  (retire_wbreg),
    .retire_wbdata (retire_wbdata),
    .trace_if      (tif.master),
    .drop_cnt      (drop_cnt),
    .drop_clr      (drop_clr),
    .overflow      (overflow)
`ifdef TRACE_EXEC_R3_SHADOW_EN
    ,
    .r3_shadow     (r3_shadow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_retire(input logic [31:0] pc, input logic [31:0] insn, input logic wben,
                            input logic [4:0] wbreg, input logic [31:0] wbdata);
    retire_valid  = 1'b1;
    retire_pc     = pc;
    retire_insn   = insn;
    retire_wben   = wben;
    retire_wbreg  = wbreg;
    retire_wbdata = wbdata;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic wben,
                        input logic [4:0] wbreg, input logic [31:0] wbdata);
    set_retire(pc, insn, wben, wbreg, wbdata);
    tick();
    retire_valid = 1'b0;
  endtask

  initial begin
    logic [102:0] exp_word;
    logic [31:0]  exp_pc [4];

    rst_sys       = 1'b1;
    retire_valid  = 1'b0;
    retire_pc     = '0;
    retire_insn   = '0;
    retire_wben   = 1'b0;
    retire_wbreg  = '0;
    retire_wbdata = '0;
    drop_clr      = 1'b0;
    tif.trace_ready = 1'b1;
    tick();
    tick();
    rst_sys = 1'b0;

    check("reset_valid", tif.trace_valid, 1'b0);
    check("reset_drop_cnt", drop_cnt, 16'h0);
    check("reset_overflow", overflow, 1'b0);

    // Single retire with r3 writeback
    retire(32'h100, 32'h1500_0000, 1'b1, 5'd3, 32'hCAFE);
    exp_word = {32'h0000_CAFE, 5'd3, 1'b1, 32'h0000_0100, 32'h1500_0000, 1'b1};
    check("single_valid", tif.trace_valid, 1'b1);
    check("single_word", tif.trace_word, exp_word);
    check("single_enable", tif.trace_word[0], 1'b1);
    check("single_pc", tif.trace_word[64:33], 32'h100);
    check("single_wbreg", tif.trace_word[70:66], 5'd3);
`ifdef TRACE_EXEC_R3_SHADOW_EN
    check("single_r3_shadow", r3_shadow, 32'hCAFE);
`endif
    tick();
    check("single_drained", tif.trace_valid, 1'b0);

    // Write to r0 must not be flagged as a writeback
    retire(32'h104, 32'h0000_0013, 1'b1, 5'd0, 32'h1234);
    check("r0_valid", tif.trace_valid, 1'b1);
    check("r0_wben", tif.trace_word[65], 1'b0);
    check("r0_wbreg", tif.trace_word[70:66], 5'd0);
    check("r0_wbdata", tif.trace_word[102:71], 32'h1234);
    check("r0_insn", tif.trace_word[32:1], 32'h13);
`ifdef TRACE_EXEC_R3_SHADOW_EN
    check("r0_r3_shadow", r3_shadow, 32'hCAFE);
`endif
    tick();
    check("r0_drained", tif.trace_valid, 1'b0);

    // Overflow: six retires into a depth-4 FIFO with the consumer stalled
    tif.trace_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_retire(32'(4 * i), 32'h0000_0013, 1'b1, 5'd7, 32'(i));
      tick();
    end
    retire_valid = 1'b0;
    check("ovf_drop_cnt", drop_cnt, 16'd2);
    check("ovf_overflow", overflow, 1'b1);
    check("ovf_stall_pc", tif.trace_word[64:33], 32'h0);
    tick();
    check("ovf_stable_pc", tif.trace_word[64:33], 32'h0);
    tif.trace_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ovf_drain_valid", tif.trace_valid, 1'b1);
      check("ovf_drain_pc", tif.trace_word[64:33], 32'(4 * i));
      tick();
    end
    check("ovf_drain_empty", tif.trace_valid, 1'b0);

    // Full FIFO with pop and retire in the same cycle
    tif.trace_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_retire(32'h30 + 32'(4 * i), 32'h0000_0013, 1'b0, 5'd7, 32'h0);
      tick();
    end
    tif.trace_ready = 1'b1;
    set_retire(32'h40, 32'h0000_0013, 1'b0, 5'd7, 32'h0);
    check("fullpop_head_pc", tif.trace_word[64:33], 32'h30);
    tick();
    retire_valid = 1'b0;
    check("fullpop_no_drop", drop_cnt, 16'd2);
    exp_pc[0] = 32'h34;
    exp_pc[1] = 32'h38;
    exp_pc[2] = 32'h3C;
    exp_pc[3] = 32'h40;
    for (int i = 0; i < 4; i++) begin
      check("fullpop_valid", tif.trace_valid, 1'b1);
      check("fullpop_pc", tif.trace_word[64:33], exp_pc[i]);
      tick();
    end
    check("fullpop_empty", tif.trace_valid, 1'b0);

    // drop_clr alone
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    check("clr_drop_cnt", drop_cnt, 16'd0);
    check("clr_overflow", overflow, 1'b0);

    // Saturation, then clear coinciding with a drop
    tif.trace_ready = 1'b0;
    set_retire(32'h500, 32'h0000_0013, 1'b1, 5'd7, 32'h0);
    repeat (4) tick();
    check("sat_no_drop_yet", drop_cnt, 16'd0);
    repeat (65540) tick();
    check("sat_drop_cnt", drop_cnt, 16'hFFFF);
    check("sat_overflow", overflow, 1'b1);
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    retire_valid = 1'b0;
    check("clr_drop_wins_cnt", drop_cnt, 16'd1);
    check("clr_drop_wins_ovf", overflow, 1'b1);

    // Reset with three buffered entries; retires during reset are ignored
    tif.trace_ready = 1'b1;
    tick();
    tif.trace_ready = 1'b0;
    check("prerst_valid", tif.trace_valid, 1'b1);
    rst_sys = 1'b1;
    set_retire(32'h999, 32'h0000_0013, 1'b1, 5'd3, 32'hDEAD);
    tick();
    rst_sys = 1'b0;
    retire_valid = 1'b0;
    check("rst_valid", tif.trace_valid, 1'b0);
    check("rst_drop_cnt", drop_cnt, 16'd0);
    check("rst_overflow", overflow, 1'b0);
`ifdef TRACE_EXEC_R3_SHADOW_EN
    check("rst_r3_shadow", r3_shadow, 32'h0);
`endif
    tick();
    check("rst_idle_valid", tif.trace_valid, 1'b0);
    tif.trace_ready = 1'b1;
    retire(32'h200, 32'h0000_0013, 1'b0, 5'd1, 32'h0);
    check("postrst_valid", tif.trace_valid, 1'b1);
    check("postrst_pc", tif.trace_word[64:33], 32'h200);
    tick();
    check("postrst_empty", tif.trace_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_exec_packer.md
Name: trace_exec_packer

Overview:
- Per-core producer of the execution-trace word consumed by the debug system and the bench trace decoders.
- Captures retired-instruction events from the CPU: PC, instruction, register writeback.
- Packs each event into the fixed trace layout and buffers it in a small FIFO.
- Emits the packed words over a valid/ready stream, counting any events dropped on overflow.

Parameters:
- FIFO_DEPTH, 4, number of buffered trace entries; power of two, minimum 2.
- DROP_CNT_WIDTH, 16, width of the saturating dropped-event counter.

Ports:
- clk  input  1  system clock
- rst_sys  input  1  synchronous active-high reset
- retire_valid  input  1  one instruction retired this cycle
- retire_pc  input  32  PC of the retired instruction
- retire_insn  input  32  instruction word
- retire_wben  input  1  instruction writes a GPR
- retire_wbreg  input  5  destination GPR index
- retire_wbdata  input  32  writeback value
- trace_valid  output  1  trace_word holds a valid entry
- trace_ready  input  1  consumer accepts trace_word
- trace_word  output  103  packed trace entry (layout below)
- drop_cnt  output  DROP_CNT_WIDTH  saturating count of events lost to overflow
- drop_clr  input  1  clears drop_cnt
- overflow  output  1  sticky: at least one event dropped since the last drop_clr

Behaviour:
- Layout, LSB first:
  - enable [0]
  - insn [32:1]
  - pc [64:33]
  - wben [65]
  - wbreg [70:66]
  - wbdata [102:71]
  - Total width 103.
  - enable is 1 in every word presented with trace_valid=1.
- Packing: wben is forced to 0 when retire_wbreg==0 (r0 hardwired). wbreg and wbdata are passed unmodified.
- Push: occurs when retire_valid=1 and the FIFO is not full, or the FIFO is full and a pop occurs in the same cycle.
- Pop: occurs when trace_valid && trace_ready.
- Latency: registered FIFO, no fall-through. An event retired in cycle N into an empty FIFO appears on trace_word in cycle N+1.
- trace_word: holds the head entry, stable while trace_valid=1 and trace_ready=0. Its value is don't-care when trace_valid=0; the bench must only compare it under trace_valid=1.
- Ordering: strict FIFO order, no reordering.
- Full, no pop, retire_valid=1:
  - Event discarded.
  - drop_cnt increments, saturating at all-ones.
  - overflow set.
- Empty with simultaneous push: trace_valid rises next cycle; no bypass.
- Pointers: read/write pointers wrap modulo FIFO_DEPTH. An extra MSB distinguishes full from empty.
- drop_clr:
  - Clears drop_cnt and overflow next cycle.
  - If drop_clr and a drop coincide, the drop wins: drop_cnt=1, overflow=1.
- Reset, values one cycle after rst_sys sampled high:
  - trace_valid=0, drop_cnt=0, overflow=0.
  - FIFO empty.
  - Events presented during reset are ignored.
  - Reset mid-stream discards all buffered entries.

Optional Feature:
- Macro: TRACE_EXEC_R3_SHADOW_EN.
- When defined:
  - Adds output port r3_shadow [31:0], reset 0.
  - Updated one cycle after a pushed event with wben=1 and wbreg==3, to that event's wbdata.
  - Updated at push time, independent of drain.
  - Dropped events do not update it.
  - Used for CPU-level self-check (exit code in r3).
- When undefined: the port and register are absent; everything else is unchanged.

Decomposition:
- Package trace_exec_pkg:
  - TRACE_EXEC_WIDTH=103.
  - Field LSB/MSB localparams matching the layout above.
  - Packed struct typedef trace_exec_t with fields enable, insn, pc, wben, wbreg, wbdata.
- One sub-module trace_exec_fifo: synchronous FIFO parameterised by width and depth, exposing push/pop/full/empty.
- Packing logic, counter and optional shadow live in the top module.

Test Plan:
- Single retire, pc=0x100, insn=0x15000000, wben=1, wbreg=3, wbdata=0xCAFE, trace_ready=1 -> next cycle trace_valid=1 with fields decoded exactly. With the macro, r3_shadow=0xCAFE.
- Retire with wbreg=0, wben=1, wbdata=0x1234 -> emitted word has wben=0, wbreg=0, wbdata=0x1234; r3_shadow unchanged.
- trace_ready=0, 6 back-to-back retires, pc=0x0,0x4,…,0x14, FIFO_DEPTH=4:
  - drop_cnt=2, overflow=1.
  - After releasing ready, exactly pc 0x0,0x4,0x8,0xC drain, in order.
- FIFO full with simultaneous pop and retire pc=0x40 -> no drop; 0x40 emitted fifth.
- drop_cnt forced to 0xFFFF via repeated drops -> stays 0xFFFF. drop_clr together with a drop -> drop_cnt=1.
- rst_sys asserted with 3 buffered entries -> next cycle trace_valid=0, drop_cnt=0, overflow=0. Following retire pc=0x200 emitted first.
